// File: rtl/load_store_unit_pkg.sv
// Shared RV32I memory-stage definitions.
// funct3 size codes, LSU state encoding and strobe constants.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: legality, store strobes,
// store-data replication and load extraction/extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic        legal,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [7:0]  bv;
  logic [15:0] hv;

  always_comb begin
    bv = mem_rdata[7:0];
    unique case (off)
      2'd0:    bv = mem_rdata[7:0];
      2'd1:    bv = mem_rdata[15:8];
      2'd2:    bv = mem_rdata[23:16];
      default: bv = mem_rdata[31:24];
    endcase
    hv = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    legal     = 1'b0;
    wstrb     = STRB_NONE;
    wdata_rep = wdata;
    load_data = mem_rdata;
    unique case (funct3)
      F3_B: begin
        legal     = 1'b1;
        wstrb     = STRB_B << off;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {{24{bv[7]}}, bv};
      end
      F3_BU: begin
        legal     = !we;
        load_data = {24'b0, bv};
      end
      F3_H: begin
        legal     = !off[0];
        wstrb     = STRB_H << off;
        wdata_rep = {2{wdata[15:0]}};
        load_data = {{16{hv[15]}}, hv};
      end
      F3_HU: begin
        legal     = !we && !off[0];
        load_data = {16'b0, hv};
      end
      F3_W: begin
        legal     = (off == 2'b00);
        wstrb     = STRB_W;
      end
      default: legal = 1'b0;
    endcase
    // loads never drive byte enables
    if (!we) wstrb = STRB_NONE;
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one req/ack bus access per start,
// stalls the datapath until done, flags misaligned accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            busy,
  output logic            done,
  output logic            misaligned,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  lsu_state_e      state_q, state_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:2] addr_q;
  logic [3:0]      wstrb_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;

  logic            idle;
  logic            a_we;
  logic [2:0]      a_f3;
  logic [1:0]      a_off;
  logic            legal;
  logic [3:0]      a_wstrb;
  logic [XLEN-1:0] a_wdata;
  logic [XLEN-1:0] a_load;

  // decode live inputs while idle, latched copy while on the bus
  assign idle  = (state_q == S_IDLE);
  assign a_we  = idle ? we : we_q;
  assign a_f3  = idle ? funct3 : f3_q;
  assign a_off = idle ? addr[1:0] : off_q;

  lsu_align u_align (
    .we        (a_we),
    .funct3    (a_f3),
    .off       (a_off),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .legal     (legal),
    .wstrb     (a_wstrb),
    .wdata_rep (a_wdata),
    .load_data (a_load)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = legal ? S_REQ : S_ERR;
      S_REQ:   if (mem_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      addr_q  <= '0;
      wstrb_q <= STRB_NONE;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle && start && legal) begin
        we_q    <= we;
        f3_q    <= funct3;
        off_q   <= addr[1:0];
        addr_q  <= addr[XLEN-1:2];
        wstrb_q <= a_wstrb;
        wdata_q <= a_wdata;
      end
      if (state_q == S_REQ && mem_ack && !we_q)
        rdata_q <= a_load;
    end
  end

  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_req && we_q;
  assign mem_wstrb  = mem_req ? wstrb_q : STRB_NONE;
  assign mem_addr   = {addr_q, 2'b00};
  assign mem_wdata  = wdata_q;
  assign rdata      = rdata_q;
  assign busy       = (idle && start) || mem_req;
  assign done       = (state_q == S_DONE) || (state_q == S_ERR);
  assign misaligned = (state_q == S_ERR);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected results queued
// at issue, popped and compared on each done pulse.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  load_store_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .we         (we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] mwdata;
    logic        mwe;
  } exp_t;

  exp_t        sb[$];
  int          n_err = 0;
  int          n_chk = 0;
  int          cyc = 0;
  int          done_cyc;
  int          req_cyc;
  logic [31:0] model_rdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run(input logic        w,
                     input logic [2:0]  f3,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] rd,
                     input int          dly,
                     input logic        ill,
                     input logic [3:0]  strb,
                     input logic [31:0] mwd,
                     input logic [31:0] ld);
    exp_t e, g;
    int   c, r;
    bit   fin;
    if (!ill && !w) model_rdata = ld;
    e.rdata  = model_rdata;
    e.mis    = ill;
    e.maddr  = {a[31:2], 2'b00};
    e.strb   = strb;
    e.mwdata = mwd;
    e.mwe    = w;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; we = w; funct3 = f3;
    addr = a; wdata = wd; mem_rdata = rd; mem_ack = 1'b0;
    @(negedge clk);
    check("busy_c0", {31'b0, busy}, 32'd1);
    check("done_c0", {31'b0, done}, 32'd0);
    c = 0; r = 0; fin = 0; req_cyc = -1;
    while (!fin && c < 40) begin
      @(posedge clk); #1;
      c++;
      mem_ack = 1'b0;
      if (done) begin
        start = 1'b0;
        fin = 1;
        done_cyc = cyc;
        @(negedge clk);
        if (sb.size() == 0) begin
          check("sb_empty", 32'd0, 32'd1);
        end else begin
          g = sb.pop_front();
          check("rdata", rdata, g.rdata);
          check("misaligned", {31'b0, misaligned}, {31'b0, g.mis});
          check("busy_done", {31'b0, busy}, 32'd0);
          check("req_done", {31'b0, mem_req}, 32'd0);
        end
      end else if (mem_req) begin
        r++;
        if (r == 1) req_cyc = cyc;
        if (r == dly + 1) mem_ack = 1'b1;
        @(negedge clk);
        check("mem_addr", mem_addr, e.maddr);
        check("mem_we", {31'b0, mem_we}, {31'b0, e.mwe});
        check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e.strb});
        if (w) check("mem_wdata", mem_wdata, e.mwdata);
        check("busy_req", {31'b0, busy}, 32'd1);
      end
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    check("latency", c, ill ? 32'd1 : dly + 2);
    if (ill) check("no_req", r, 32'd0);
  endtask

  initial begin
    int d1;
    reset = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b0;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_flags", {28'b0, busy, done, misaligned, mem_req}, 32'h0);
    check("rst_bus", {27'b0, mem_we, mem_wstrb}, 32'h0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_mwdata", mem_wdata, 32'h0);
    reset = 1'b0;

    run(0, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
        4'b0000, 32'h0, 32'hDEADBEEF);
    run(0, F3_B,  32'h103, 32'h0, 32'h80FF7F01, 1, 0,
        4'b0000, 32'h0, 32'hFFFFFF80);
    run(0, F3_BU, 32'h103, 32'h0, 32'h80FF7F01, 0, 0,
        4'b0000, 32'h0, 32'h00000080);
    run(1, F3_H,  32'h22, 32'h1234ABCD, 32'h0, 3, 0,
        4'b1100, 32'hABCDABCD, 32'h0);
    run(0, F3_W,  32'h102, 32'h0, 32'h55555555, 0, 1,
        4'b0000, 32'h0, 32'h0);
    run(1, F3_B,  32'h11, 32'h000000A5, 32'h0, 2, 0,
        4'b0010, 32'hA5A5A5A5, 32'h0);
    run(1, F3_W,  32'h40, 32'hCAFEF00D, 32'h0, 0, 0,
        4'b1111, 32'hCAFEF00D, 32'h0);
    d1 = done_cyc;
    run(0, F3_HU, 32'h6, 32'h0, 32'h8001FFFF, 0, 0,
        4'b0000, 32'h0, 32'h00008001);
    check("b2b_gap", req_cyc - d1, 32'd2);
    run(0, F3_H,  32'h2, 32'h0, 32'h8001FFFF, 1, 0,
        4'b0000, 32'h0, 32'hFFFF8001);
    run(1, F3_BU, 32'h8, 32'h0, 32'h0, 0, 1,
        4'b0000, 32'h0, 32'h0);
    run(0, 3'b011, 32'h8, 32'h0, 32'h0, 0, 1,
        4'b0000, 32'h0, 32'h0);
    run(1, F3_H,  32'h1, 32'h0, 32'h0, 0, 1,
        4'b0000, 32'h0, 32'h0);
    run(0, F3_HU, 32'h3, 32'h0, 32'h0, 0, 1,
        4'b0000, 32'h0, 32'h0);

    // reset while waiting on the bus
    @(posedge clk); #1;
    start = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h200;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_req", {31'b0, mem_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid", {29'b0, mem_req, busy, done}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_ackign", {30'b0, mem_req, done}, 32'h0);
    end
    check("rst_rdata2", rdata, 32'h0);
    mem_ack = 1'b0;
    model_rdata = 32'h0;
    run(0, F3_B, 32'h201, 32'h0, 32'h0000C300, 0, 0,
        4'b0000, 32'h0, 32'hFFFFFFC3);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
